// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scalar-multiply controller.
//   N_DEF          default field element / scalar width
//   OP_ADD/OP_DBL  encoding of op_dbl towards the point unit
//   state_t        controller state encoding
//   sel_t          ADD_REQ decision produced by ecc_point_sel
package ecc_pkg;

   localparam int   N_DEF  = 231;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_DBL = 1'b1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SCAN     = 3'd1,
      DBL_REQ  = 3'd2,
      DBL_WAIT = 3'd3,
      ADD_REQ  = 3'd4,
      ADD_WAIT = 3'd5,
      NEXT     = 3'd6,
      FIN      = 3'd7
   } state_t;

   // What ADD_REQ does with the current scalar bit.
   typedef enum logic [2:0] {
      SEL_SKIP  = 3'd0,  // bit is 0
      SEL_LOADP = 3'd1,  // Q is infinity: Q = P without an op
      SEL_DBL   = 3'd2,  // Q == P: add degenerates to doubling P
      SEL_INF   = 3'd3,  // Q == -P: sum is infinity, no op
      SEL_ADD   = 3'd4   // generic add Q + P
   } sel_t;

endpackage

// File: rtl/ecc_point_sel.sv
// Combinational Q-versus-P classifier for the add step of double-and-add.
// Picks the action that keeps the point unit away from a zero denominator.
// Ports:
//   bit_set        current scalar bit k[idx]
//   q_inf          accumulator is the point at infinity
//   qx, qy         accumulator coordinates
//   px, py         base point coordinates
//   sel            decision, encoded as ecc_pkg::sel_t
module ecc_point_sel
   import ecc_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         bit_set,
   input  logic         q_inf,
   input  logic [N-1:0] qx,
   input  logic [N-1:0] qy,
   input  logic [N-1:0] px,
   input  logic [N-1:0] py,
   output logic [2:0]   sel
);

   logic x_eq;
   logic y_eq;

   assign x_eq = (qx == px);
   assign y_eq = (qy == py);

   // Equal x with unequal y can only mean Q == -P on a valid curve point.
   always_comb begin
      sel = SEL_ADD;
      if (!bit_set)
         sel = SEL_SKIP;
      else if (q_inf)
         sel = SEL_LOADP;
      else if (x_eq && y_eq)
         sel = SEL_DBL;
      else if (x_eq)
         sel = SEL_INF;
   end

endmodule

// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer computing Q = k*P on a shared
// point add/double unit. The point at infinity is tracked locally so the
// unit is never handed operands that would need a zero inverse.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, k, p, px, py  command; operands captured on an accepted start
//   busy, done           busy while running; done pulses with the result
//   qx, qy, q_inf        result (qx = qy = 0 when q_inf)
//   op_start, op_dbl     request pulse / double-vs-add to the point unit
//   op_ax..op_by, op_p   operands held from op_start through op_done
//   op_done, op_rx, op_ry, op_rinf  point unit response
module ecc_scalar_mult_ctrl
   import ecc_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int IW = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] k,
   input  logic [N-1:0] p,
   input  logic [N-1:0] px,
   input  logic [N-1:0] py,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] qx,
   output logic [N-1:0] qy,
   output logic         q_inf,
   output logic         op_start,
   output logic         op_dbl,
   output logic [N-1:0] op_ax,
   output logic [N-1:0] op_ay,
   output logic [N-1:0] op_bx,
   output logic [N-1:0] op_by,
   output logic [N-1:0] op_p,
   input  logic         op_done,
   input  logic [N-1:0] op_rx,
   input  logic [N-1:0] op_ry,
   input  logic         op_rinf
);

   state_t         state, state_nxt;

   logic [N-1:0]   k_r, px_r, py_r;
   logic [IW-1:0]  idx;
   logic [N-1:0]   acc_x, acc_y;
   logic           acc_inf;
   logic [2:0]     sel;

   // control strobes from the FSM to the datapath
   logic ld_args, idx_dec, q_from_p, q_to_inf, q_from_res;
   logic issue, issue_dbl, a_from_p, fin;

   ecc_point_sel #(.N(N)) u_sel (
      .bit_set (k_r[idx]),
      .q_inf   (acc_inf),
      .qx      (acc_x),
      .qy      (acc_y),
      .px      (px_r),
      .py      (py_r),
      .sel     (sel)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      ld_args    = 1'b0;
      idx_dec    = 1'b0;
      q_from_p   = 1'b0;
      q_to_inf   = 1'b0;
      q_from_res = 1'b0;
      issue      = 1'b0;
      issue_dbl  = 1'b0;
      a_from_p   = 1'b0;
      fin        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               ld_args   = 1'b1;
               state_nxt = SCAN;
            end
         end
         // One bit per cycle, so k == 0 costs exactly N scan cycles.
         SCAN: begin
            if (k_r[idx]) begin
               q_from_p = 1'b1;
               if (idx == '0)
                  state_nxt = FIN;
               else begin
                  idx_dec   = 1'b1;
                  state_nxt = DBL_REQ;
               end
            end else if (idx == '0) begin
               q_to_inf  = 1'b1;
               state_nxt = FIN;
            end else
               idx_dec = 1'b1;
         end
         DBL_REQ: begin
            if (acc_inf)
               state_nxt = ADD_REQ;
            else begin
               issue     = 1'b1;
               issue_dbl = 1'b1;
               state_nxt = DBL_WAIT;
            end
         end
         DBL_WAIT: begin
            if (op_done) begin
               q_from_res = 1'b1;
               state_nxt  = ADD_REQ;
            end
         end
         ADD_REQ: begin
            state_nxt = NEXT;
            case (sel_t'(sel))
               SEL_LOADP: q_from_p = 1'b1;
               SEL_INF:   q_to_inf = 1'b1;
               SEL_DBL: begin
                  issue     = 1'b1;
                  issue_dbl = 1'b1;
                  a_from_p  = 1'b1;
                  state_nxt = ADD_WAIT;
               end
               SEL_ADD: begin
                  issue     = 1'b1;
                  state_nxt = ADD_WAIT;
               end
               default: ;
            endcase
         end
         ADD_WAIT: begin
            if (op_done) begin
               q_from_res = 1'b1;
               state_nxt  = NEXT;
            end
         end
         NEXT: begin
            if (idx == '0)
               state_nxt = FIN;
            else begin
               idx_dec   = 1'b1;
               state_nxt = DBL_REQ;
            end
         end
         FIN: begin
            fin       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         qx       <= '0;
         qy       <= '0;
         q_inf    <= 1'b0;
         op_start <= 1'b0;
         op_dbl   <= OP_ADD;
         op_ax    <= '0;
         op_ay    <= '0;
         op_bx    <= '0;
         op_by    <= '0;
         op_p     <= '0;
         k_r      <= '0;
         px_r     <= '0;
         py_r     <= '0;
         idx      <= '0;
         acc_x    <= '0;
         acc_y    <= '0;
         acc_inf  <= 1'b0;
      end else begin
         done     <= fin;
         op_start <= issue;

         if (ld_args) begin
            k_r     <= k;
            op_p    <= p;
            px_r    <= px;
            py_r    <= py;
            idx     <= IW'(N - 1);
            acc_inf <= 1'b1;
            busy    <= 1'b1;
         end

         if (idx_dec)
            idx <= idx - IW'(1);

         if (q_from_p) begin
            acc_x   <= px_r;
            acc_y   <= py_r;
            acc_inf <= 1'b0;
         end
         if (q_to_inf)
            acc_inf <= 1'b1;
         if (q_from_res) begin
            acc_x   <= op_rx;
            acc_y   <= op_ry;
            acc_inf <= op_rinf;
         end

         // Operands are only written on issue, so they stay put until op_done.
         if (issue) begin
            op_dbl <= issue_dbl ? OP_DBL : OP_ADD;
            op_ax  <= a_from_p ? px_r : acc_x;
            op_ay  <= a_from_p ? py_r : acc_y;
            op_bx  <= px_r;
            op_by  <= py_r;
         end

         if (fin) begin
            busy  <= 1'b0;
            qx    <= acc_inf ? '0 : acc_x;
            qy    <= acc_inf ? '0 : acc_y;
            q_inf <= acc_inf;
         end
      end
   end

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Bench for ecc_scalar_mult_ctrl on y^2 = x^3 + 2x + 2 over GF(17), N = 8.
// A behavioural point unit (3-cycle latency) answers the controller; results
// are compared with k*P computed by plain repeated addition of P.
module tb_ecc_scalar_mult_ctrl;

   localparam int N  = 8;
   localparam int PR = 17;

   logic         clk, reset, start;
   logic [N-1:0] k, p, px, py;
   logic         busy, done, q_inf;
   logic [N-1:0] qx, qy;
   logic         op_start, op_dbl, op_done, op_rinf;
   logic [N-1:0] op_ax, op_ay, op_bx, op_by, op_p, op_rx, op_ry;

   int n_cmp = 0;
   int n_bad = 0;

   ecc_scalar_mult_ctrl #(.N(N)) dut (
      .clk(clk), .reset(reset), .start(start), .k(k), .p(p), .px(px), .py(py),
      .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf),
      .op_start(op_start), .op_dbl(op_dbl), .op_ax(op_ax), .op_ay(op_ay),
      .op_bx(op_bx), .op_by(op_by), .op_p(op_p), .op_done(op_done),
      .op_rx(op_rx), .op_ry(op_ry), .op_rinf(op_rinf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- GF(17) curve arithmetic ----------------
   function automatic int md(input int x);
      return ((x % PR) + PR) % PR;
   endfunction

   function automatic int inv(input int a);
      int r = 1;
      int b = md(a);
      for (int i = 0; i < PR - 2; i++) r = md(r * b);
      return r;
   endfunction

   // returns {inf, x, y}
   function automatic logic [2*N:0] pt_add(input logic ai, input logic [N-1:0] ax, ay,
                                           input logic bi, input logic [N-1:0] bx, by);
      int xa, ya, xb, yb, l, rx, ry;
      if (ai) return {bi, bx, by};
      if (bi) return {ai, ax, ay};
      xa = int'(ax); ya = int'(ay); xb = int'(bx); yb = int'(by);
      if (xa == xb) begin
         if (md(ya + yb) == 0) return {1'b1, {(2*N){1'b0}}};
         l = md(md(3 * xa * xa + 2) * inv(2 * ya));
      end else
         l = md(md(yb - ya) * inv(xb - xa));
      rx = md(l * l - xa - xb);
      ry = md(l * (xa - rx) - ya);
      return {1'b0, N'(rx), N'(ry)};
   endfunction

   function automatic logic [2*N:0] ref_mul(input logic [N-1:0] bx, by, input int kv);
      logic [2*N:0] q = {1'b1, {(2*N){1'b0}}};
      for (int i = 0; i < kv; i++)
         q = pt_add(q[2*N], q[2*N-1:N], q[N-1:0], 1'b0, bx, by);
      return q;
   endfunction

   // ---------------- behavioural point unit ----------------
   logic         u_done, u_rinf;
   logic [N-1:0] u_rx, u_ry;
   logic [2*N:0] u_res;
   int           u_cnt;
   int           viol;
   logic         inj_done;
   logic [N-1:0] inj_rx, inj_ry;

   always_comb begin
      u_res = '0;
      if (op_dbl) u_res = pt_add(1'b0, op_ax, op_ay, 1'b0, op_ax, op_ay);
      else        u_res = pt_add(1'b0, op_ax, op_ay, 1'b0, op_bx, op_by);
   end

   initial viol = 0;
   always @(posedge clk) begin
      if (reset) begin
         u_done <= 1'b0;
         u_cnt  <= 0;
      end else begin
         u_done <= 1'b0;
         if (op_start) begin
            // overlapping requests, or an add whose x difference is zero
            viol   <= viol + ((u_cnt != 0) ? 1 : 0) + ((!op_dbl && op_ax == op_bx) ? 1 : 0);
            u_cnt  <= 3;
            u_rinf <= u_res[2*N];
            u_rx   <= u_res[2*N-1:N];
            u_ry   <= u_res[N-1:0];
         end else if (u_cnt > 0) begin
            u_cnt <= u_cnt - 1;
            if (u_cnt == 1) u_done <= 1'b1;
         end
      end
   end

   assign op_done = u_done | inj_done;
   assign op_rx   = inj_done ? inj_rx : u_rx;
   assign op_ry   = inj_done ? inj_ry : u_ry;
   assign op_rinf = inj_done ? 1'b0 : u_rinf;

   // ---------------- transaction driver ----------------
   logic         lg_dbl [64];
   logic [N-1:0] lg_ax [64], lg_ay [64], lg_bx [64], lg_by [64];

   // lat = clock edges from the start-accepting edge to the edge raising done
   task automatic run(input int kv, input logic [N-1:0] bx, by, input bit glitch,
                      output int ops, output int lat);
      int  cyc = 1;
      bit  got = 0;
      ops = 0;
      @(negedge clk);
      k = N'(kv); px = bx; py = by; p = N'(PR); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("busy_k%0d", kv), busy, 1);
      while (!got && cyc < 3000) begin
         if (op_start) begin
            if (ops < 64) begin
               lg_dbl[ops] = op_dbl;
               lg_ax[ops] = op_ax; lg_ay[ops] = op_ay;
               lg_bx[ops] = op_bx; lg_by[ops] = op_by;
            end
            ops++;
         end
         if (done) got = 1;
         else begin
            if (glitch && cyc == 4) begin
               start = 1'b1; k = 8'd5; px = 8'd0; py = 8'd0;
            end else
               start = 1'b0;
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      if (!got) chk($sformatf("done_timeout_k%0d", kv), 0, 1);
      lat = cyc - 1;
      chk($sformatf("busy_at_done_k%0d", kv), busy, 0);
   endtask

   task automatic check_res(input string tag, input logic [N-1:0] ex, ey, input logic einf);
      chk({tag, "_qx"}, qx, ex);
      chk({tag, "_qy"}, qy, ey);
      chk({tag, "_qinf"}, q_inf, einf);
   endtask

   int           ops, lat, cyc;
   logic [2*N:0] base, exp_q;
   bit           saw;

   initial begin
      reset = 1'b1; start = 1'b0; k = '0; p = N'(PR); px = 8'd5; py = 8'd1;
      inj_done = 1'b0; inj_rx = '0; inj_ry = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_qinf", q_inf, 0);
      chk("rst_opstart", op_start, 0);
      reset = 1'b0;

      run(1, 8'd5, 8'd1, 0, ops, lat);
      check_res("k1", 8'd5, 8'd1, 1'b0);
      chk("k1_ops", ops, 0);

      run(2, 8'd5, 8'd1, 0, ops, lat);
      check_res("k2", 8'd6, 8'd3, 1'b0);
      chk("k2_ops", ops, 1);
      chk("k2_dbl", lg_dbl[0], 1);

      run(3, 8'd5, 8'd1, 0, ops, lat);
      check_res("k3", 8'd10, 8'd6, 1'b0);
      chk("k3_ops", ops, 2);
      chk("k3_op1_dbl", lg_dbl[1], 0);
      chk("k3_op1_a", {lg_ax[1], lg_ay[1]}, {8'd6, 8'd3});
      chk("k3_op1_b", {lg_bx[1], lg_by[1]}, {8'd5, 8'd1});

      run(18, 8'd5, 8'd1, 0, ops, lat);
      check_res("k18", 8'd5, 8'd16, 1'b0);

      run(19, 8'd5, 8'd1, 0, ops, lat);
      check_res("k19", 8'd0, 8'd0, 1'b1);
      chk("k19_ops", ops, 5);

      // 21 = 0b10101: last add finds Q == P and must be turned into a double of P
      run(21, 8'd5, 8'd1, 0, ops, lat);
      check_res("k21", 8'd6, 8'd3, 1'b0);
      chk("k21_last_dbl", lg_dbl[ops-1], 1);
      chk("k21_last_a", {lg_ax[ops-1], lg_ay[ops-1]}, {8'd5, 8'd1});

      run(0, 8'd5, 8'd1, 0, ops, lat);
      check_res("k0", 8'd0, 8'd0, 1'b1);
      chk("k0_ops", ops, 0);
      chk("k0_latency", lat, N + 1);

      // abort in DBL_WAIT, then a stale op_done must be ignored
      @(negedge clk);
      k = 8'd19; px = 8'd5; py = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!(op_start && op_dbl) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_saw_dbl", op_start && op_dbl, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_opstart", op_start, 0);
      check_res("abort", 8'd0, 8'd0, 1'b0);
      chk("abort_op_a", {op_ax, op_ay}, 0);
      chk("abort_op_p", op_p, 0);
      inj_rx = 8'd3; inj_ry = 8'd7; inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      saw = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy || done || op_start) saw = 1;
      end
      chk("stale_done_ignored", saw, 0);
      check_res("stale", 8'd0, 8'd0, 1'b0);

      // a second start while busy must not disturb the k=3 job
      run(3, 8'd5, 8'd1, 1, ops, lat);
      check_res("k3_glitch", 8'd10, 8'd6, 1'b0);
      chk("k3_glitch_ops", ops, 2);

      // random scalars on random multiples of P as base point
      for (int t = 0; t < 12; t++) begin
         int r  = $urandom_range(1, 18);
         int kv = $urandom_range(0, 255);
         base  = ref_mul(8'd5, 8'd1, r);
         exp_q = ref_mul(base[2*N-1:N], base[N-1:0], kv);
         run(kv, base[2*N-1:N], base[N-1:0], 0, ops, lat);
         check_res($sformatf("rnd%0d_r%0d_k%0d", t, r, kv),
                   exp_q[2*N] ? 8'd0 : exp_q[2*N-1:N],
                   exp_q[2*N] ? 8'd0 : exp_q[N-1:0], exp_q[2*N]);
         if (kv == 0) chk($sformatf("rnd%0d_k0_latency", t), lat, N + 1);
      end

      repeat (2) @(negedge clk);
      chk("unit_protocol_violations", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ecc_scalar_mult_ctrl.md
Name: ecc_scalar_mult_ctrl

Overview:
Sequences a shared point-arithmetic unit (point add / point double over GF(p)) to compute Q = k*P using left-to-right double-and-add.
- Tracks the point-at-infinity locally and never issues an operation whose operands would make the unit divide by zero.
- Sits between the top-level ECC command interface and the point add/double datapath.

Parameters:
N, 231, field element and scalar width in bits
IW, $clog2(N), width of the scalar bit index

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
k  input  N  scalar; captured on accepted start
p  input  N  field prime; captured on accepted start
px  input  N  base point x; captured on accepted start
py  input  N  base point y; captured on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; result valid from this cycle
qx  output  N  result x; holds until next accepted start
qy  output  N  result y; holds until next accepted start
q_inf  output  1  result is the point at infinity
op_start  output  1  one-cycle pulse to the point unit
op_dbl  output  1  1 = double A, 0 = add A+B; valid with op_start
op_ax, op_ay, op_bx, op_by  output  N each  operands; stable from op_start through op_done
op_p  output  N  captured prime
op_done  input  1  one-cycle pulse; op_rx/op_ry/op_rinf valid in this cycle
op_rx, op_ry  input  N each  operation result
op_rinf  input  1  operation result is infinity

Behaviour:
- Reset (only reset style): state=IDLE; busy, done, op_start, q_inf = 0; qx, qy, all op_* operands = 0. Reset mid-operation aborts immediately. A later op_done is ignored in IDLE. The point unit shares the same reset.
- States: IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, NEXT, FIN.
- IDLE:
  - On start: latch k, p, px, py; idx = N-1; go to SCAN.
  - A start while busy is ignored.
- SCAN:
  - Skip leading zeros one bit per cycle.
  - k==0: go to FIN with Q=inf.
  - At the first set bit: Q=(px,py), Qinf=0. If idx==0, go to FIN; else decrement idx and go to DBL_REQ.
- DBL_REQ:
  - Qinf=1: Q stays inf; no op issued; go to ADD_REQ.
  - Otherwise: pulse op_start with op_dbl=1, A=Q; go to DBL_WAIT.
- DBL_WAIT: on op_done, Q=(op_rx,op_ry), Qinf=op_rinf; go to ADD_REQ.
- ADD_REQ (uses k[idx]):
  - bit=0: go to NEXT.
  - bit=1 and Qinf: Q=P, Qinf=0, no op.
  - bit=1 and Qx==px with Qy==py: issue a double (op_dbl=1, A=P).
  - bit=1 and Qx==px with Qy!=py: Qinf=1, no op.
  - bit=1 otherwise: op_dbl=0, A=Q, B=P; go to ADD_WAIT.
  - Every no-op path goes to NEXT.
- ADD_WAIT: on op_done, latch result as in DBL_WAIT; go to NEXT.
- NEXT: if idx==0, go to FIN; else decrement idx and go to DBL_REQ.
- FIN:
  - Drive qx/qy=Q, q_inf=Qinf, done=1; busy=0 next cycle; return to IDLE.
  - When Qinf=1, qx=qy=0.
- op_start is never asserted while an operation is outstanding. op_done arriving outside a WAIT state is ignored.
- No timeout; the controller waits indefinitely in the WAIT states.
- Latency:
  - k==0: done exactly N+1 cycles after start.
  - Otherwise: scan cycles + per processed bit (2 control cycles + op latencies).

Decomposition:
- Shared package ecc_pkg: state enum encoding, N default, OP_ADD/OP_DBL encodings.
- One natural sub-module: ecc_point_sel. It is combinational and compares Q vs P (x equal, y equal), producing the add/double/infinity/skip decision for ADD_REQ.

Test Plan:
All scenarios use curve y^2=x^3+2x+2 over p=17, P=(5,1), N=8, with a behavioural point unit of 3-cycle op latency.
- k=1 -> zero op_start pulses; done with (qx,qy)=(5,1), q_inf=0.
- k=2 -> exactly one op_start with op_dbl=1; result (6,3).
- k=3 -> one double then one add (A=(6,3), B=(5,1)); result (10,6).
- k=18 -> result (5,16). k=19 -> final step detects Qx==px, Qy!=py, issues no op; q_inf=1, qx=qy=0.
- k=0 -> zero op_start pulses; done N+1 cycles after start; q_inf=1.
- reset asserted in DBL_WAIT during k=19, then a stale op_done -> outputs stay at reset values, busy=0. A new start with k=3 then yields (10,6). A start pulsed while busy is ignored.
